// File: rtl/trap_wave_gen_pkg.sv
// Shared types for the trapezoid/triangle/sawtooth generator:
// FSM phase encoding (also driven on the phase output) and mode encodings.
package wave_gen_pkg;

  typedef enum logic [1:0] {
    RISE    = 2'd0,
    HOLD_HI = 2'd1,
    FALL    = 2'd2,
    HOLD_LO = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_TRAP = 2'd0,
    MODE_TRI  = 2'd1,
    MODE_SAW  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

endpackage

// File: rtl/trap_wave_gen_if.sv
// Configuration/control and waveform output bundle of trap_wave_gen.
// The master drives configuration and enable; the slave (generator) drives the waveform.
interface trap_wave_gen_if #(
  parameter int DW = 9,
  parameter int CW = 8
);
  logic          en;
  logic [1:0]    mode;
  logic [DW-1:0] lo_lvl;
  logic [DW-1:0] hi_lvl;
  logic [DW-1:0] step;
  logic [CW-1:0] hold_hi;
  logic [CW-1:0] hold_lo;
  logic [DW-1:0] d_out;
  logic [1:0]    phase;
  logic          period_done;

  modport master (
    output en, mode, lo_lvl, hi_lvl, step, hold_hi, hold_lo,
    input  d_out, phase, period_done
  );

  modport slave (
    input  en, mode, lo_lvl, hi_lvl, step, hold_hi, hold_lo,
    output d_out, phase, period_done
  );
endinterface

// File: rtl/trap_wave_gen_hold_cnt.sv
// Dwell counter shared by the HOLD_HI and HOLD_LO phases; o_match flags
// that the count has reached the programmed terminal value.
module wave_hold_cnt #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_inc,
  input  logic [CW-1:0] i_term,
  output logic          o_match
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_match = (r_cnt == i_term);

endmodule

// File: rtl/trap_wave_gen.sv
// Trapezoid / triangle / sawtooth waveform generator.
// Define WAVE_GEN_CFG_LATCH_EN to sample configuration only at reset and period starts.
module trap_wave_gen
  import wave_gen_pkg::*;
#(
  parameter int DW = 9,
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            res,
  trap_wave_gen_if.slave  bus
);

  logic [DW-1:0] w_lo, w_hi, w_step_raw, w_step;
  logic [CW-1:0] w_hold_hi, w_hold_lo, w_term;
  mode_t         w_mode;
  logic [DW:0]   w_up, w_lo_up;
  logic          w_flat, w_in_hold, w_cnt_match, w_cnt_clr, w_cnt_inc;
  logic [DW-1:0] w_d_nxt;
  state_t        w_st_nxt;
  logic          w_pd_nxt, w_period_start;

  logic [DW-1:0] r_d_out;
  state_t        r_state;
  logic          r_pd;

  assign w_period_start = bus.en & w_pd_nxt;

`ifdef WAVE_GEN_CFG_LATCH_EN
  logic [DW-1:0] r_lo, r_hi, r_step;
  logic [CW-1:0] r_hold_hi, r_hold_lo;
  mode_t         r_mode;

  always_ff @(posedge clk) begin
    if (res || w_period_start) begin
      r_lo      <= bus.lo_lvl;
      r_hi      <= bus.hi_lvl;
      r_step    <= bus.step;
      r_hold_hi <= bus.hold_hi;
      r_hold_lo <= bus.hold_lo;
      r_mode    <= mode_t'(bus.mode);
    end
  end

  assign w_lo       = r_lo;
  assign w_hi       = r_hi;
  assign w_step_raw = r_step;
  assign w_hold_hi  = r_hold_hi;
  assign w_hold_lo  = r_hold_lo;
  assign w_mode     = r_mode;
`else
  assign w_lo       = bus.lo_lvl;
  assign w_hi       = bus.hi_lvl;
  assign w_step_raw = bus.step;
  assign w_hold_hi  = bus.hold_hi;
  assign w_hold_lo  = bus.hold_lo;
  assign w_mode     = mode_t'(bus.mode);
`endif

  // One extra bit on both ramp sums so a step near full scale cannot wrap.
  assign w_step  = (w_step_raw == '0) ? DW'(1) : w_step_raw;
  assign w_up    = {1'b0, r_d_out} + {1'b0, w_step};
  assign w_lo_up = {1'b0, w_lo} + {1'b0, w_step};
  assign w_flat  = (w_hi <= w_lo);

  assign w_in_hold = (r_state == HOLD_HI) || (r_state == HOLD_LO);
  assign w_term    = (r_state == HOLD_HI) ? w_hold_hi : w_hold_lo;
  assign w_cnt_inc = bus.en & ~w_flat & w_in_hold & ~w_cnt_match;
  assign w_cnt_clr = bus.en & (w_flat | ~w_in_hold | w_cnt_match);

  wave_hold_cnt #(.CW(CW)) u_hold_cnt (
    .clk     (clk),
    .rst     (res),
    .i_clr   (w_cnt_clr),
    .i_inc   (w_cnt_inc),
    .i_term  (w_term),
    .o_match (w_cnt_match)
  );

  always_comb begin
    w_d_nxt  = r_d_out;
    w_st_nxt = r_state;
    w_pd_nxt = 1'b0;
    if (w_flat) begin
      w_d_nxt  = w_lo;
      w_st_nxt = HOLD_LO;
    end else begin
      case (r_state)
        RISE: begin
          if (w_mode == MODE_SAW) begin
            if (r_d_out >= w_hi) begin
              w_d_nxt  = w_lo;
              w_pd_nxt = 1'b1;
            end else if (w_up >= {1'b0, w_hi}) begin
              w_d_nxt = w_hi;
            end else begin
              w_d_nxt = w_up[DW-1:0];
            end
          end else if (w_up >= {1'b0, w_hi}) begin
            w_d_nxt  = w_hi;
            w_st_nxt = (w_mode == MODE_TRI) ? FALL : HOLD_HI;
          end else begin
            w_d_nxt = w_up[DW-1:0];
          end
        end
        HOLD_HI: begin
          if (w_cnt_match) w_st_nxt = FALL;
        end
        FALL: begin
          if ({1'b0, r_d_out} <= w_lo_up) begin
            w_d_nxt = w_lo;
            if (w_mode == MODE_TRI) begin
              w_st_nxt = RISE;
              w_pd_nxt = 1'b1;
            end else begin
              w_st_nxt = HOLD_LO;
            end
          end else begin
            w_d_nxt = r_d_out - w_step;
          end
        end
        HOLD_LO: begin
          if (w_cnt_match) begin
            w_st_nxt = RISE;
            w_pd_nxt = 1'b1;
          end
        end
        default: w_st_nxt = RISE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_d_out <= '0;
      r_state <= RISE;
      r_pd    <= 1'b0;
    end else begin
      r_pd <= w_period_start;
      if (bus.en) begin
        r_d_out <= w_d_nxt;
        r_state <= w_st_nxt;
      end
    end
  end

  assign bus.d_out       = r_d_out;
  assign bus.phase       = r_state;
  assign bus.period_done = r_pd;

endmodule

// File: doc/trap_wave_gen.md
TRAP_WAVE_GEN -- requirements
Module: trap_wave_gen

Interface
REQ-001 Parameter DW, default 9, d_out and level/step width in bits.
REQ-002 Parameter CW, default 8, hold-counter and hold-length width in bits.
REQ-003 clk  input  1  rising-edge clock; sole clock domain.
REQ-004 res  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  advance enable; 0 freezes all state.
REQ-006 mode  input  2  0 trapezoid, 1 triangle, 2 sawtooth, 3 reserved (behaves as 0).
REQ-007 lo_lvl  input  DW  lower waveform level.
REQ-008 hi_lvl  input  DW  upper waveform level.
REQ-009 step  input  DW  per-cycle ramp increment; 0 treated as 1.
REQ-010 hold_hi  input  CW  top flat length minus one, in cycles.
REQ-011 hold_lo  input  CW  bottom flat length minus one, in cycles.
REQ-012 d_out  output  DW  waveform sample, registered.
REQ-013 phase  output  2  current state: 0 RISE, 1 HOLD_HI, 2 FALL, 3 HOLD_LO.
REQ-014 period_done  output  1  one-cycle pulse at each period start.

Function
REQ-015 All decisions occur on enabled cycles (en=1, res=0); en=0 holds d_out, phase, hold counter; period_done=0.
REQ-016 Level compares use DW+1-bit arithmetic; no wrap-around of d_out.
REQ-017 RISE: if d_out+step >= hi_lvl, d_out<=hi_lvl and next state HOLD_HI (mode 0/3) or FALL (mode 1); else d_out<=d_out+step.
REQ-018 HOLD_HI: counter increments from 0; at count==hold_hi, clear counter, go FALL; dwell = hold_hi+1 cycles.
REQ-019 FALL: if d_out <= lo_lvl+step, d_out<=lo_lvl and next state HOLD_LO (mode 0/3) or RISE with period_done (mode 1); else d_out<=d_out-step.
REQ-020 HOLD_LO: count to hold_lo as REQ-018, then go RISE and assert period_done next cycle.
REQ-021 Mode 2: RISE only; when d_out >= hi_lvl at cycle start, d_out<=lo_lvl, period_done; sequence reaches hi_lvl exactly once per period.
REQ-022 hi_lvl <= lo_lvl: d_out<=lo_lvl, state HOLD_LO, counter cleared, no period_done, every enabled cycle.
REQ-023 Mode change mid-period takes effect at next state decision; d_out never jumps except clamps/wrap above.
REQ-024 period_done high exactly one cycle, coincident with first cycle of new period.

Reset
REQ-025 res=1 at clk edge: d_out=0, phase=RISE, hold counter=0, period_done=0, regardless of en.
REQ-026 res mid-operation aborts current period immediately; ramp restarts from 0 on next enabled cycle.

Configuration
REQ-027 Macro WAVE_GEN_CFG_LATCH_EN defined: lo_lvl, hi_lvl, step, hold_hi, hold_lo, mode captured into shadow registers while res=1 and at each period start; waveform uses shadows only.
REQ-028 Macro undefined: configuration inputs used live every cycle; no shadow registers.

Structure
REQ-029 Package wave_gen_pkg holds state enum (RISE/HOLD_HI/FALL/HOLD_LO) and mode encodings.
REQ-030 Sub-module wave_hold_cnt (CW-bit counter, clear, enable, terminal-match output) used for both holds.

Verification
REQ-031 Defaults, mode 0, lo 0, hi 299, step 1, holds 200, en=1 after reset -> d_out 299 after 299 cycles, flat 201, back to 0 after 299, period_done every 1000 cycles.
REQ-032 Mode 1, lo 10, hi 20, step 3 -> d_out 0,3,..,18,20,17,14,11,10,13,...; period_done on each 10->13 transition.
REQ-033 Mode 2, lo 0, hi 7, step 1 -> d_out 0..7,0 repeating; period 8 cycles; one pulse per wrap.
REQ-034 Toggle en low for 50 cycles during HOLD_HI -> d_out, phase frozen; period lengthens by exactly 50.
REQ-035 Assert res during FALL at d_out=150 -> next cycle d_out=0, phase=0, no period_done.
REQ-036 With WAVE_GEN_CFG_LATCH_EN, change hi to 100 mid-RISE -> current peak 299; following period peaks at 100. Without it -> clamps to 100 immediately.
